// File: rtl/wbs_charlie_keys.sv
// Wishbone B4 pipelined slave scanning a charlieplexed 7-pin, 42-key matrix with debounce and an event FIFO.
// Optional interrupt output is enabled by defining WBS_CHARLIE_KEYS_IRQ_EN.
module wbs_charlie_keys #(
    parameter int unsigned WB_CLK_HZ  = 0,
    parameter int unsigned SCAN_HZ    = 100000,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        wbs_clk_i,
    input  logic        wbs_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_stall_o,
    output logic        wbs_ack_o,
    output logic [6:0]  keys_o,
    output logic [6:0]  keys_oe,
    input  logic [6:0]  keys_i
`ifdef WBS_CHARLIE_KEYS_IRQ_EN
    ,
    output logic        irq_o
`endif
);

    localparam int unsigned DWELL   = WB_CLK_HZ / SCAN_HZ;
    localparam int unsigned DWELL_C = (DWELL < 10) ? 10 : DWELL;
    localparam int          CW      = $clog2(DWELL_C);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(DWELL_C - 8);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FILL_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_DRIVE  = 2'd0,
        S_SAMPLE = 2'd1,
        S_EMIT   = 2'd2
    } scan_state_t;

    scan_state_t   r_fsm;
    logic [2:0]    r_col;
    logic [CW-1:0] r_cnt;
    logic [6:0]    r_oe;
    logic [5:0]    r_raw;
    logic [41:0]   r_state;
    logic [41:0]   r_prev;
    logic [6:0]    r_meta;
    logic [6:0]    r_sync;

    logic [1:0]    r_ctrl;
    logic          r_ack;
    logic [31:0]   r_dat;

    logic [6:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr;
    logic [AW:0]   r_rd;
    logic          r_ovf;

    logic [5:0]    w_raw;
    logic [5:0]    w_idx;
    logic [2:0]    w_k;
    logic          w_bit;
    logic          w_evt_hit;
    logic [6:0]    w_evt;
    logic          w_req;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [AW:0]   w_count;
    logic          w_empty;
    logic          w_full;
    logic [6:0]    w_head;
    logic [7:0]    w_cnt8;
    logic [31:0]   w_rdata;
    logic          w_unused;

    assign wbs_stall_o = 1'b0;
    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = r_dat;
    assign keys_o      = 7'd0;
    assign keys_oe     = r_oe;
    assign w_unused    = ^wbs_dat_i;

    always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
        if (wbs_rst_i) begin
            r_meta <= 7'd0;
            r_sync <= 7'd0;
        end else begin
            r_meta <= keys_i;
            r_sync <= r_meta;
        end
    end

    // Pins are pulled up, so a pressed key reads low; raw holds active-high presses with the driven pin removed.
    always_comb begin
        w_raw = 6'd0;
        for (int k = 0; k < 6; k++) begin
            if (k < int'(r_col))
                w_raw[k] = ~r_sync[k];
            else
                w_raw[k] = ~r_sync[k+1];
        end
    end

    assign w_k       = r_cnt[2:0];
    assign w_idx     = 6'(r_col) * 6'd6 + 6'(w_k);
    assign w_bit     = r_raw[w_k];
    assign w_evt_hit = (r_fsm == S_EMIT) && (w_bit == r_prev[w_idx]) && (w_bit != r_state[w_idx]);
    assign w_evt     = {w_bit, w_idx};

    always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
        if (wbs_rst_i) begin
            r_fsm   <= S_DRIVE;
            r_col   <= 3'd0;
            r_cnt   <= '0;
            r_oe    <= 7'd0;
            r_raw   <= 6'd0;
            r_state <= 42'd0;
            r_prev  <= 42'd0;
        end else if (!r_ctrl[0]) begin
            r_fsm <= S_DRIVE;
            r_col <= 3'd0;
            r_cnt <= '0;
            r_oe  <= 7'd0;
        end else begin
            r_oe <= 7'd1 << r_col;
            case (r_fsm)
                S_DRIVE: begin
                    if (r_cnt == DRIVE_LAST) begin
                        r_cnt <= '0;
                        r_fsm <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    r_raw <= w_raw;
                    r_cnt <= '0;
                    r_fsm <= S_EMIT;
                end
                S_EMIT: begin
                    r_prev[w_idx] <= w_bit;
                    if (w_evt_hit)
                        r_state[w_idx] <= w_bit;
                    if (r_cnt == CW'(5)) begin
                        r_cnt <= '0;
                        r_col <= (r_col == 3'd6) ? 3'd0 : r_col + 3'd1;
                        r_fsm <= S_DRIVE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_fsm <= S_DRIVE;
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign w_req   = wbs_cyc_i & wbs_stb_i;
    assign w_count = r_wr - r_rd;
    assign w_empty = (r_wr == r_rd);
    assign w_full  = (w_count == FILL_FULL);
    assign w_head  = r_mem[r_rd[AW-1:0]];
    assign w_cnt8  = 8'(w_count);
    assign w_pop   = w_req & ~wbs_we_i & (wbs_adr_i == 4'h1) & ~w_empty;
    // A same-cycle pop frees the slot the push needs, so a full FIFO only drops when nothing is popped.
    assign w_push  = w_evt_hit & (~w_full | w_pop);
    assign w_drop  = w_evt_hit & w_full & ~w_pop;

    always_ff @(posedge wbs_clk_i) begin
        if (w_push)
            r_mem[r_wr[AW-1:0]] <= w_evt;
    end

    always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
        if (wbs_rst_i) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_push)
                r_wr <= r_wr + 1'b1;
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            if (w_drop)
                r_ovf <= 1'b1;
            else if (w_req && wbs_we_i && (wbs_adr_i == 4'h0) && wbs_dat_i[8])
                r_ovf <= 1'b0;
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        case (wbs_adr_i)
            4'h0:    w_rdata = {22'd0, w_empty, r_ovf, w_cnt8};
            4'h1:    w_rdata = w_empty ? 32'd0 : {24'd0, 1'b1, w_head};
            4'h2:    w_rdata = r_state[31:0];
            4'h3:    w_rdata = {22'd0, r_state[41:32]};
            4'h4:    w_rdata = {30'd0, r_ctrl};
            default: w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
        if (wbs_rst_i) begin
            r_ack  <= 1'b0;
            r_dat  <= 32'd0;
            r_ctrl <= 2'b01;
        end else begin
            r_ack <= w_req;
            r_dat <= (w_req && !wbs_we_i) ? w_rdata : 32'd0;
            if (w_req && wbs_we_i && (wbs_adr_i == 4'h4)) begin
                r_ctrl[0] <= wbs_dat_i[0];
`ifdef WBS_CHARLIE_KEYS_IRQ_EN
                r_ctrl[1] <= wbs_dat_i[1];
`endif
            end
        end
    end

`ifdef WBS_CHARLIE_KEYS_IRQ_EN
    logic r_irq;

    always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
        if (wbs_rst_i)
            r_irq <= 1'b0;
        else
            r_irq <= r_ctrl[1] & ~w_empty;
    end

    assign irq_o = r_irq;
`endif

endmodule

// File: doc/wbs_charlie_keys.md
Name: wbs_charlie_keys

Overview:
- Wishbone B4 pipelined slave that scans a charlieplexed 7-pin key matrix of 42 keys (7 columns x 6 rows) and presents the keys to the CPU.
- It is the input counterpart of the charlieplexed LED driver and sits on the same peripheral bus.
- Debounced key state is readable as a bitmap.
- Press and release edges are queued in an event FIFO that the CPU pops through a register.

Parameters:
- WB_CLK_HZ, 0, bus clock frequency in Hz; must be nonzero at instantiation.
- SCAN_HZ, 100000, column step rate. DWELL = WB_CLK_HZ/SCAN_HZ cycles per column; DWELL must be >= 10.
- FIFO_DEPTH, 16, event FIFO entries; must be a power of 2, at most 128.

Ports:
- wbs_clk_i  in  1  bus clock, sole clock.
- wbs_rst_i  in  1  reset, asynchronous, active-high.
- wbs_cyc_i  in  1  bus cycle.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  write enable.
- wbs_adr_i  in  4  word address.
- wbs_dat_i  in  32  write data.
- wbs_dat_o  out  32  read data, registered, valid with ack.
- wbs_stall_o  out  1  tied 0.
- wbs_ack_o  out  1  acknowledge.
- keys_o  out  7  pin output value, always 0.
- keys_oe  out  7  pin output enable, one-hot on the driven column.
- keys_i  in  7  pin input, externally pulled up; 0 means pressed.

Behaviour:
- Reset (async assert, sync release) clears:
  - ack, dat_o, keys_oe, column counter, dwell counter, FIFO pointers, overflow flag;
  - state[41:0], prev[41:0], sync flops.
  - CTRL resets to 0x1.
- Bus: request = cyc & stb. ack is asserted the cycle after every request (single-cycle latency). No stall. Back-to-back requests get back-to-back acks.
- Register map (word addresses):
  - 0x0 STATUS. Read: [7:0] FIFO count, [8] overflow, [9] empty. Write with dat[8]=1 clears overflow.
  - 0x1 EVENT. Read pops the FIFO head: [5:0] key index, [6] 1=press / 0=release, [7] valid. Pop on empty returns 0x00 and changes nothing. Writes are ignored.
  - 0x2 STATE0. Read returns state[31:0].
  - 0x3 STATE1. Read returns {22'b0, state[41:32]}.
  - 0x4 CTRL, read/write. [0] scan enable, [1] irq enable (see Optional Feature).
  - All other addresses read 0; writes to them are ignored.
- Key index mapping: key (column c, row pin r), r != c, gets index = c*6 + (r<c ? r : r-1). Example: c=2, r=5 gives index 16.
- keys_i passes through a 2-flop synchronizer before use.
- Scan FSM:
  - DRIVE: keys_oe = 1<<col for DWELL-7 cycles (settling).
  - SAMPLE (1 cycle): latch the synchronized pins into raw[5:0], compacted by skipping pin col.
  - EMIT (6 cycles, k=0..5): for key i = col*6+k,
    - if raw[k]==prev[i] and raw[k]!=state[i]: toggle state[i] and push event {raw[k]==0, i};
    - always set prev[i] <= raw[k].
  - Then col <= (col==6) ? 0 : col+1 and return to DRIVE.
  - keys_oe stays on the column through SAMPLE and EMIT.
- Debounce: a state change requires two consecutive sweeps with the same sample. Minimum press-to-event latency is 2 sweeps.
- FIFO:
  - Push when full: the event is dropped and overflow is set (sticky). state still updates.
  - Push and pop in the same cycle: both take effect; count is unchanged. A pop on a full FIFO frees a slot before the push.
- CTRL[0]=0:
  - keys_oe forced to 0, FSM held in DRIVE with col=0 and counters 0;
  - state, prev and FIFO retained.
  - Re-enabling starts from column 0.
- Reset mid-scan or mid-transaction aborts immediately. No ack is issued for a request in flight.

Optional Feature:
- Macro WBS_CHARLIE_KEYS_IRQ_EN.
- When defined:
  - adds output irq_o (1 bit) = CTRL[1] & ~empty, registered, reset 0;
  - CTRL[1] is read/write.
- When undefined:
  - no irq_o port;
  - CTRL[1] reads 0 and writes to it are ignored.

Test Plan:
- Test parameters: WB_CLK_HZ=1000000, SCAN_HZ=100000, so DWELL=10 and one sweep is 70 cycles.
- Idle after reset:
  - keys_oe cycles 0x01,0x02,...,0x40 and wraps, each value held 10 cycles;
  - STATUS reads 0x200; CTRL reads 0x1; ack arrives 1 cycle after stb.
- Hold pin 5 low while col 2 is driven, for 3 sweeps:
  - after sweep 2, STATE0 bit 16 = 1 and STATUS count = 1;
  - EVENT read returns 0xD0; a second EVENT read returns 0x00.
- Release key 16 for 3 sweeps -> EVENT returns 0x90; STATE0 returns 0.
- Bounce: key 16 pressed for 1 sweep only (not held across 2 consecutive sweeps) -> no event, state unchanged.
- Toggle 20 distinct keys with no reads:
  - count saturates at 16 and overflow=1;
  - the first 16 events pop in order;
  - writing 0x100 to STATUS clears overflow.
- Write CTRL=0:
  - keys_oe = 0 within 1 cycle and the state bitmap is frozen;
  - write CTRL=1 and scanning resumes at keys_oe = 0x01.
  - With the macro defined and CTRL=0x3: irq_o rises after the first event and falls after the final pop.
